// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and output bundle for the multicycle MIPS main control.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ANDI  = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

  // state     | meaning
  // FETCH     | read instruction, PC += 4 when memory is ready
  // DECODE    | dispatch on opcode/funct, precompute branch target
  // MEM_*     | lw/sw address, read, write-back, write
  // R_*/IMM_* | ALU execute and register write-back
  // BRANCH    | beq compare; JAL/JR | jump
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Target of the DECODE dispatch; FETCH here means the instruction is unsupported.
  function automatic state_t dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    state_t nxt;
    nxt = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:     nxt = S_MEM_ADDR;
      OP_BEQ:           nxt = S_BRANCH;
      OP_ADDI, OP_ANDI: nxt = S_IMM_EXEC;
      OP_JAL:           nxt = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_JR: nxt = S_JR;
          FN_ADD, FN_SLL, FN_AND, FN_NOR, FN_SLT: nxt = S_R_EXEC;
          default: nxt = S_FETCH;
        endcase
      end
      default: nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_main_control_out_decode.sv
// Combinational output decode from the registered state plus the FETCH/DECODE qualifiers.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [5:0] op_latched,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.illegal   = (dispatch(opcode, funct) == S_FETCH);
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RT;
          ctrl.mem_to_reg = MTR_MDR;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALUOP_RTYPE;
        end
        S_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RD;
          ctrl.mem_to_reg = MTR_ALUOUT;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_IMM_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = (op_latched == OP_ANDI) ? ALUOP_ANDI : ALUOP_ADD;
        end
        S_IMM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RT;
          ctrl.mem_to_reg = MTR_ALUOUT;
        end
        S_JAL: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RA;
          ctrl.mem_to_reg = MTR_PC;
        end
        S_JR: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_REG_A;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register, next-state logic and opcode latch.
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_q;
  logic [5:0] op_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          state_q <= dispatch(opcode, funct);
          op_q    <= opcode;
        end
        S_MEM_ADDR:  state_q <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= S_R_WB;
        S_IMM_EXEC:  state_q <= S_IMM_WB;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_out_decode u_out_decode (
    .rst        (rst),
    .state      (state_q),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .funct      (funct),
    .op_latched (op_q),
    .ctrl       (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: instruction vector table plus reset/wait sequences.
module tb_mips_main_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;
  } obs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    logic [23:0] seq;
    logic       andi;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic illegal;

  obs_t act;
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  mips_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal(illegal)
  );

  assign act = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write,
                alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, state, illegal};

  // Expected outputs for a state, written directly from the per-state output table.
  function automatic obs_t exp_for(logic [3:0] st, logic mr, logic andi, logic ill);
    obs_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      4'd1:  begin e.alu_src_b = 2'b11; e.illegal = ill; end
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
      4'd5:  begin e.mem_write = 1; e.i_or_d = 1; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      4'd7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
      4'd8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      4'd9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = andi ? 2'b11 : 2'b00; end
      4'd10: begin e.reg_write = 1; end
      4'd11: begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1; e.reg_dst = 2'b10;
                   e.mem_to_reg = 2'b10; end
      4'd12: begin e.pc_write = 1; e.pc_source = 2'b11; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic vec_t mk(string nm, logic [5:0] op, logic [5:0] fn, int len,
                              logic [23:0] seq, logic andi, logic ill);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.len = len; v.seq = seq; v.andi = andi; v.ill = ill;
    return v;
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare mid-cycle, advance past the edge.
  // Opcode/funct are the instruction's only in DECODE so the opcode latch is exercised.
  task automatic do_cycle(string nm, logic mr, logic in_decode, logic [5:0] op, logic [5:0] fn,
                          obs_t e);
    obs_t want;
    mem_ready = mr;
    opcode    = in_decode ? op : ~op;
    funct     = in_decode ? fn : ~fn;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state got %0d want %0d)", nm, act, want,
               act.state, want.state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic st_cycle(string nm, logic [3:0] st, logic mr, logic [5:0] op, logic [5:0] fn,
                          logic andi, logic ill);
    do_cycle(nm, mr, st == 4'd1, op, fn, exp_for(st, mr, andi, ill));
  endtask

  initial begin
    vecs[0]  = mk("lw",      6'b100011, 6'b000000, 5, 24'h043210, 0, 0);
    vecs[1]  = mk("sw",      6'b101011, 6'b000000, 4, 24'h005210, 0, 0);
    vecs[2]  = mk("add",     6'b000000, 6'b100000, 4, 24'h007610, 0, 0);
    vecs[3]  = mk("nor",     6'b000000, 6'b100111, 4, 24'h007610, 0, 0);
    vecs[4]  = mk("andi",    6'b001100, 6'b000000, 4, 24'h00A910, 1, 0);
    vecs[5]  = mk("addi",    6'b001000, 6'b111111, 4, 24'h00A910, 0, 0);
    vecs[6]  = mk("beq",     6'b000100, 6'b000000, 3, 24'h000810, 0, 0);
    vecs[7]  = mk("jal",     6'b000011, 6'b000000, 3, 24'h000B10, 0, 0);
    vecs[8]  = mk("jr",      6'b000000, 6'b001000, 3, 24'h000C10, 0, 0);
    vecs[9]  = mk("ill_op",  6'b111111, 6'b000000, 2, 24'h000010, 0, 1);
    vecs[10] = mk("ill_fn",  6'b000000, 6'b000110, 2, 24'h000010, 0, 1);
    vecs[11] = mk("slt",     6'b000000, 6'b101010, 4, 24'h007610, 0, 0);
    vecs[12] = mk("and_sll", 6'b000000, 6'b100100, 4, 24'h007610, 0, 0);

    rst = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0;
    @(posedge clk); #1;
    do_cycle("reset0", 1, 0, 6'd0, 6'd0, '0);
    do_cycle("reset1", 1, 0, 6'd0, 6'd0, '0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].len; i++) begin
        st_cycle($sformatf("%s c%0d", vecs[k].name, i), vecs[k].seq[4*i +: 4], 1'b1,
                 vecs[k].op, vecs[k].fn, vecs[k].andi, vecs[k].ill);
      end
    end

    // sw with two wait cycles in MEM_WRITE; mem_ready low in DECODE/MEM_ADDR must be ignored
    st_cycle("sw_wait c0", 4'd0, 1, 6'b101011, 6'd0, 0, 0);
    st_cycle("sw_wait c1", 4'd1, 0, 6'b101011, 6'd0, 0, 0);
    st_cycle("sw_wait c2", 4'd2, 0, 6'b101011, 6'd0, 0, 0);
    st_cycle("sw_wait c3", 4'd5, 0, 6'b101011, 6'd0, 0, 0);
    st_cycle("sw_wait c4", 4'd5, 0, 6'b101011, 6'd0, 0, 0);
    st_cycle("sw_wait c5", 4'd5, 1, 6'b101011, 6'd0, 0, 0);

    // lw stalled in MEM_READ, then reset for three cycles cancels it
    st_cycle("lw_rst c0", 4'd0, 1, 6'b100011, 6'd0, 0, 0);
    st_cycle("lw_rst c1", 4'd1, 1, 6'b100011, 6'd0, 0, 0);
    st_cycle("lw_rst c2", 4'd2, 1, 6'b100011, 6'd0, 0, 0);
    st_cycle("lw_rst c3", 4'd3, 0, 6'b100011, 6'd0, 0, 0);
    st_cycle("lw_rst c4", 4'd3, 0, 6'b100011, 6'd0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle($sformatf("mid_rst %0d", i), 1, 0, 6'd0, 6'd0, '0);
    rst = 1'b0;

    // First free cycle is FETCH; stall it, then complete a beq
    st_cycle("post_rst c0", 4'd0, 0, 6'b000100, 6'd0, 0, 0);
    st_cycle("post_rst c1", 4'd0, 0, 6'b000100, 6'd0, 0, 0);
    st_cycle("post_rst c2", 4'd0, 1, 6'b000100, 6'd0, 0, 0);
    st_cycle("post_rst c3", 4'd1, 1, 6'b000100, 6'd0, 0, 0);
    st_cycle("post_rst c4", 4'd8, 1, 6'b000100, 6'd0, 0, 0);
    st_cycle("post_rst c5", 4'd0, 1, 6'b000100, 6'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multicycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives the datapath enables and produces the 2-bit ALUOp consumed by the ALU control unit, which combines it with the funct field into the 4-bit ALU operation. It sits between the instruction register (opcode/funct) and the datapath, and waits on a single memory-ready handshake.

## Interface
- No parameters. Opcodes, functs and ALUOp codes are fixed constants in the package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; sampled only in DECODE.
- `funct` in 6: IR[5:0]; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `alu_src_a` out 1: datapath enables and selects.
- `reg_dst` out 2: write-register select; 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: write-data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_b` out 2: ALU B-input select; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `alu_op` out 2: ALU operation class; 00 = add, 01 = subtract/compare, 10 = R-type (use funct), 11 = AND immediate.
- `pc_source` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `state` out 4: current state, for debug.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5.
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, IMM_EXEC = 9, IMM_WB = 10, JAL = 11, JR = 12.
- All outputs not listed for a state are 0.
- **FETCH**
  - Outputs: `mem_read` = 1, `i_or_d` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00.
  - `ir_write` and `pc_write` = 1 only in the cycle where `mem_ready` = 1.
  - Transition: to DECODE on `mem_ready`; otherwise stay in FETCH.
- **DECODE**
  - Outputs: `alu_src_b` = 11, `alu_op` = 00 (branch-target precompute).
  - Dispatch on opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR.
    - 000000 → R_EXEC, except funct 001000 → JR.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) or 001100 (andi) → IMM_EXEC.
    - 000011 (jal) → JAL.
    - Anything else → FETCH with `illegal` = 1.
  - R-type funct must be one of 100000, 000000, 100100, 100111, 101010; any other funct → FETCH with `illegal` = 1.
- **MEM_ADDR**: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00. Next state is MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ**: `mem_read` = 1, `i_or_d` = 1. Stay until `mem_ready`, then go to MEM_WB.
- **MEM_WB**: `reg_write` = 1, `reg_dst` = 00, `mem_to_reg` = 01. Next: FETCH.
- **MEM_WRITE**: `mem_write` = 1, `i_or_d` = 1. Stay until `mem_ready`, then go to FETCH.
- **R_EXEC**: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10. Next: R_WB.
- **R_WB**: `reg_write` = 1, `reg_dst` = 01, `mem_to_reg` = 00. Next: FETCH.
- **BRANCH**: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01. Next: FETCH.
- **IMM_EXEC**: `alu_src_a` = 1, `alu_src_b` = 10. `alu_op` = 00 for addi, 11 for andi (opcode latched in DECODE). Next: IMM_WB.
- **IMM_WB**: `reg_write` = 1, `reg_dst` = 00, `mem_to_reg` = 00. Next: FETCH.
- **JAL**: `pc_write` = 1, `pc_source` = 10, `reg_write` = 1, `reg_dst` = 10, `mem_to_reg` = 10. Next: FETCH.
- **JR**: `pc_write` = 1, `pc_source` = 11. Next: FETCH.

## Timing
- Reset:
  - `rst` high at an edge forces `state` = FETCH, cancelling any instruction, including one mid-way through a wait.
  - While `rst` is high, every output is gated to 0, including `mem_read` and `state`.
  - The first cycle with `rst` low is FETCH.
- Output timing: outputs are decoded from the registered state. The only Mealy terms are `ir_write`/`pc_write` in FETCH (qualified by `mem_ready`) and `illegal` in DECODE.
- Latency in cycles, with `mem_ready` = 1 whenever asked:
  - lw 5; sw, R-type, addi and andi 4; beq, jal and jr 3.
- Wait states: each cycle with `mem_ready` = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Outputs hold steady throughout the wait.
- `mem_ready` outside those three states is ignored.
- The latched opcode is held from DECODE until the next DECODE.

## Structure
- Package `mips_ctrl_pkg`:
  - Opcode and funct constants.
  - ALUOp codes: ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ANDI.
  - State enumeration.
  - `reg_dst`, `mem_to_reg`, `alu_src_b` and `pc_source` select codes.
- Sub-module `mips_ctrl_out_decode`: purely combinational state-plus-qualifiers → output bundle. The top level holds only the state register, the next-state logic and the opcode latch.

## Test plan
- Reset held 3 cycles mid-MEM_READ, then released → all outputs 0 during reset; `state` = 0 with `mem_read` = 1 on the first free cycle.
- lw (opcode 100011), `mem_ready` always 1 → states 0, 1, 2, 3, 4; `reg_write` = 1 with `mem_to_reg` = 01 in cycle 5; back to FETCH.
- sw with `mem_ready` low for 2 cycles in MEM_WRITE → `mem_write` held 3 cycles; `reg_write` never asserted; 6 cycles total.
- R-type funct 100111 (nor), then andi (001100) → `alu_op` = 10 in R_EXEC with `reg_dst` = 01; `alu_op` = 11 in IMM_EXEC with `reg_dst` = 00.
- beq → `pc_write_cond` = 1, `alu_op` = 01, `pc_source` = 01 in cycle 3. jr (000000/001000) → `pc_source` = 11, with no R_WB cycle.
- Opcode 111111, and R-type funct 000110 → `illegal` pulses once in DECODE; next state is FETCH; no write enable asserted.
